// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller: branch flush, multi-cycle multiply hold,
// load-use bubble and jump flush, plus a saturating stall-cycle counter.
module hazard_stall_controller #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  IF_ID_Rs,
    input  logic [4:0]  IF_ID_Rt,
    input  logic        IF_ID_UsesRt,
    input  logic        IF_ID_Jump,
    input  logic [4:0]  ID_EX_Rt,
    input  logic        ID_EX_MemRead,
    input  logic        ID_EX_MultStart,
    input  logic        EX_BranchTaken,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        ID_EX_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Bubble,
    output logic        EX_MEM_Bubble,
    output logic [15:0] StallCount
);

    // state   | meaning
    // RUN     | normal issue; branch > mult > load-use > jump
    // MULBUSY | multiply occupies EX; hold while cnt != 0, release at cnt == 0
    typedef enum logic {RUN, MULBUSY} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 2);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_q;
    logic        load_use;

    assign load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                      ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        PCWrite       = 1'b1;
        IF_ID_Write   = 1'b1;
        ID_EX_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Bubble  = 1'b0;
        EX_MEM_Bubble = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    if (EX_BranchTaken) begin
                        IF_ID_Flush  = 1'b1;
                        ID_EX_Bubble = 1'b1;
                    end else if (ID_EX_MultStart) begin
                        PCWrite       = 1'b0;
                        IF_ID_Write   = 1'b0;
                        ID_EX_Write   = 1'b0;
                        EX_MEM_Bubble = 1'b1;
                        cnt_d         = CNT_INIT;
                        state_d       = MULBUSY;
                    end else if (load_use) begin
                        PCWrite      = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                    end else if (IF_ID_Jump) begin
                        IF_ID_Flush = 1'b1;
                    end
                end
                MULBUSY: begin
                    if (cnt_q != 4'd0) begin
                        PCWrite       = 1'b0;
                        IF_ID_Write   = 1'b0;
                        ID_EX_Write   = 1'b0;
                        EX_MEM_Bubble = 1'b1;
                        cnt_d         = cnt_q - 4'd1;
                    end else begin
                        // release cycle: mult/branch inputs still ignored
                        state_d = RUN;
                        if (load_use) begin
                            PCWrite      = 1'b0;
                            IF_ID_Write  = 1'b0;
                            ID_EX_Bubble = 1'b1;
                        end else if (IF_ID_Jump) begin
                            IF_ID_Flush = 1'b1;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!PCWrite && (stall_q != 16'hFFFF))
                stall_q <= stall_q + 16'd1;
        end
    end

    assign StallCount = stall_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: two instances (MUL_CYCLES 4 and 2) against
// a cycle-indexed behavioural model, plus directed literal expectations.
module tb_hazard_stall_controller;

    localparam int MC [2] = '{4, 2};
    localparam logic [5:0] IDLE = 6'b111000;
    localparam logic [5:0] HOLD = 6'b000001;
    localparam logic [5:0] BRF  = 6'b111110;
    localparam logic [5:0] LUB  = 6'b001010;
    localparam logic [5:0] JMPF = 6'b111100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] rs = '0, rt = '0, ex_rt = '0;
    logic       uses_rt = 1'b0, jmp = 1'b0, memrd = 1'b0, ms = 1'b0, br = 1'b0;

    logic        pcw [2];
    logic        ifw [2];
    logic        idw [2];
    logic        fl  [2];
    logic        bb  [2];
    logic        eb  [2];
    logic [15:0] sc  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_controller #(.MUL_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_UsesRt(uses_rt),
        .IF_ID_Jump(jmp), .ID_EX_Rt(ex_rt), .ID_EX_MemRead(memrd),
        .ID_EX_MultStart(ms), .EX_BranchTaken(br),
        .PCWrite(pcw[0]), .IF_ID_Write(ifw[0]), .ID_EX_Write(idw[0]),
        .IF_ID_Flush(fl[0]), .ID_EX_Bubble(bb[0]), .EX_MEM_Bubble(eb[0]),
        .StallCount(sc[0]));

    hazard_stall_controller #(.MUL_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_UsesRt(uses_rt),
        .IF_ID_Jump(jmp), .ID_EX_Rt(ex_rt), .ID_EX_MemRead(memrd),
        .ID_EX_MultStart(ms), .EX_BranchTaken(br),
        .PCWrite(pcw[1]), .IF_ID_Write(ifw[1]), .ID_EX_Write(idw[1]),
        .IF_ID_Flush(fl[1]), .ID_EX_Bubble(bb[1]), .EX_MEM_Bubble(eb[1]),
        .StallCount(sc[1]));

    function automatic logic [5:0] outs(int k);
        return {pcw[k], ifw[k], idw[k], fl[k], bb[k], eb[k]};
    endfunction

    // Model: a multiply issued at cycle c holds through c+MC-2; c+MC-1 is release.
    longint cyc = 0;
    longint mend [2] = '{-1, -1};
    int     msc  [2] = '{0, 0};

    always @(negedge clk) begin
        logic [5:0] e;
        logic       lu, rel, start;
        lu = memrd && (ex_rt != 0) && ((ex_rt == rs) || (uses_rt && ex_rt == rt));
        for (int k = 0; k < 2; k++) begin
            start = 1'b0;
            if (reset) e = IDLE;
            else if (mend[k] > cyc) e = HOLD;
            else begin
                rel = (mend[k] == cyc);
                if (!rel && br) e = BRF;
                else if (!rel && ms) begin e = HOLD; start = 1'b1; end
                else if (lu) e = LUB;
                else if (jmp) e = JMPF;
                else e = IDLE;
            end
            checks++;
            if (outs(k) !== e) begin
                errors++;
                $display("FAIL model_outs dut%0d cyc=%0d got=%b exp=%b", MC[k], cyc, outs(k), e);
            end
            checks++;
            if (sc[k] !== 16'(msc[k])) begin
                errors++;
                $display("FAIL model_stallcount dut%0d cyc=%0d got=%0d exp=%0d", MC[k], cyc, sc[k], msc[k]);
            end
            if (reset) begin
                mend[k] = -1;
                msc[k]  = 0;
            end else begin
                if (start) mend[k] = cyc + MC[k] - 1;
                if (!e[5] && msc[k] < 65535) msc[k]++;
            end
        end
        cyc++;
    end

    task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic clr();
        rs = '0; rt = '0; ex_rt = '0; uses_rt = 0; jmp = 0; memrd = 0; ms = 0; br = 0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1; nxt(); nxt(); reset = 0;
    endtask

    initial begin
        clr();
        // reset: idle regardless of inputs
        br = 1; ms = 1; memrd = 1; ex_rt = 8; rs = 8; jmp = 1;
        smp(); chk("reset_idle_outs", {10'd0, outs(0)}, {10'd0, IDLE});
        nxt(); smp(); chk("reset_stallcount", sc[0], 16'd0);
        clr(); nxt(); reset = 0;
        smp(); chk("post_reset_idle", {10'd0, outs(0)}, {10'd0, IDLE});

        // load-use one cycle
        nxt(); memrd = 1; ex_rt = 8; rs = 8;
        smp(); chk("loaduse_pcwrite", {15'd0, pcw[0]}, 16'd0);
        chk("loaduse_bubble", {15'd0, bb[0]}, 16'd1);
        nxt(); clr();
        smp(); chk("loaduse_one_cycle", {15'd0, pcw[0]}, 16'd1);
        chk("loaduse_stallcount", sc[0], 16'd1);

        // no false stall
        nxt(); memrd = 1; ex_rt = 0; rs = 0;
        smp(); chk("nostall_r0", {10'd0, outs(0)}, {10'd0, IDLE});
        nxt(); memrd = 1; ex_rt = 5; rt = 5; rs = 3; uses_rt = 0;
        smp(); chk("nostall_rt_unused", {10'd0, outs(0)}, {10'd0, IDLE});
        nxt(); uses_rt = 1;
        smp(); chk("stall_rt_used", {10'd0, outs(0)}, {10'd0, LUB});
        nxt(); clr();

        // multiply
        do_reset();
        ms = 1;
        smp(); chk("mul_t_hold4", {10'd0, outs(0)}, {10'd0, HOLD});
        chk("mul_t_hold2", {10'd0, outs(1)}, {10'd0, HOLD});
        nxt(); ms = 0;
        smp(); chk("mul_t1_hold4", {15'd0, pcw[0]}, 16'd0);
        chk("mul_t1_idle2", {10'd0, outs(1)}, {10'd0, IDLE});
        nxt(); smp(); chk("mul_t2_hold4", {15'd0, pcw[0]}, 16'd0);
        nxt(); smp(); chk("mul_t3_idle4", {10'd0, outs(0)}, {10'd0, IDLE});
        chk("mul_stallcount4", sc[0], 16'd3);
        chk("mul_stallcount2", sc[1], 16'd1);
        nxt();

        // priority
        br = 1; memrd = 1; ex_rt = 8; rs = 8; jmp = 1;
        smp(); chk("priority_branch", {10'd0, outs(0)}, {10'd0, BRF});
        nxt(); clr();

        // reset mid-multiply
        do_reset();
        ms = 1; nxt(); ms = 0; reset = 1;
        smp(); chk("reset_mid_mul_idle", {10'd0, outs(0)}, {10'd0, IDLE});
        nxt(); reset = 0;
        smp(); chk("after_abort_idle", {10'd0, outs(0)}, {10'd0, IDLE});
        chk("after_abort_stallcount", sc[0], 16'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            nxt();
            reset   = ($urandom_range(49) == 0);
            br      = ($urandom_range(5) == 0);
            ms      = ($urandom_range(7) == 0);
            memrd   = ($urandom_range(2) == 0);
            jmp     = ($urandom_range(4) == 0);
            uses_rt = $urandom_range(1);
            rs      = 5'($urandom_range(3));
            rt      = 5'($urandom_range(3));
            ex_rt   = 5'($urandom_range(3));
        end
        nxt(); clr(); reset = 0;

        // saturation
        do_reset();
        memrd = 1; ex_rt = 8; rs = 8;
        repeat (65540) nxt();
        smp(); chk("sat_stallcount4", sc[0], 16'hFFFF);
        chk("sat_stallcount2", sc[1], 16'hFFFF);
        nxt(); smp(); chk("sat_hold", sc[0], 16'hFFFF);
        nxt(); clr(); nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 The module SHALL have parameter MUL_CYCLES, default 4, meaning the total number of cycles a multi-cycle multiply occupies EX; legal range 2..16.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port IF_ID_Rs, input, 5 bits: Rs field of the instruction in ID.
REQ-005 Port IF_ID_Rt, input, 5 bits: Rt field of the instruction in ID.
REQ-006 Port IF_ID_UsesRt, input, 1 bit: the ID instruction reads Rt as a source.
REQ-007 Port IF_ID_Jump, input, 1 bit: the ID instruction is J/JAL/JR.
REQ-008 Port ID_EX_Rt, input, 5 bits: destination Rt of the instruction in EX.
REQ-009 Port ID_EX_MemRead, input, 1 bit: the EX instruction is a load.
REQ-010 Port ID_EX_MultStart, input, 1 bit: a multiply entered EX this cycle.
REQ-011 Port EX_BranchTaken, input, 1 bit: a branch resolved taken in EX this cycle.
REQ-012 Outputs PCWrite, IF_ID_Write and ID_EX_Write SHALL each be 1 bit: write enables of PC, IF/ID and ID/EX.
REQ-013 Outputs IF_ID_Flush, ID_EX_Bubble and EX_MEM_Bubble SHALL each be 1 bit: zero the control fields of the named register on the next edge.
REQ-014 Output StallCount, 16 bits: registered count of cycles with PCWrite=0.

Function
REQ-015 The controller SHALL have states RUN and MULBUSY plus a 4-bit down-counter cnt; all outputs except StallCount SHALL be combinational from state, cnt and inputs.
REQ-016 The default (idle) output set SHALL be PCWrite=1, IF_ID_Write=1, ID_EX_Write=1, all flush/bubble outputs=0.
REQ-017 The "hold" output set SHALL be PCWrite=0, IF_ID_Write=0, ID_EX_Write=0, EX_MEM_Bubble=1, IF_ID_Flush=0, ID_EX_Bubble=0.
REQ-018 In RUN, events SHALL be resolved with the priority branch > mult > load-use > jump.
REQ-019 In RUN, if EX_BranchTaken=1, the controller SHALL output idle values except IF_ID_Flush=1 and ID_EX_Bubble=1, and SHALL ignore load-use and jump.
REQ-020 In RUN, otherwise, if ID_EX_MultStart=1, the controller SHALL output hold, set cnt<=MUL_CYCLES-2 and set next state to MULBUSY.
REQ-021 Load-use SHALL be defined as ID_EX_MemRead && ID_EX_Rt!=0 && (ID_EX_Rt==IF_ID_Rs || (IF_ID_UsesRt && ID_EX_Rt==IF_ID_Rt)).
REQ-022 In RUN, otherwise, on load-use the controller SHALL output PCWrite=0, IF_ID_Write=0 and ID_EX_Bubble=1 (others idle), giving exactly one bubble per occurrence; a jump in ID SHALL NOT flush in that cycle.
REQ-023 In RUN, otherwise, if IF_ID_Jump=1, the controller SHALL output idle values with IF_ID_Flush=1.
REQ-024 In MULBUSY with cnt!=0, the controller SHALL output hold and decrement cnt.
REQ-025 In MULBUSY with cnt==0 (release cycle), the controller SHALL return to RUN and evaluate load-use and jump as in RUN.
REQ-026 ID_EX_MultStart and EX_BranchTaken SHALL be ignored throughout MULBUSY.
REQ-027 A multiply SHALL be held for exactly MUL_CYCLES-1 consecutive cycles, including the issue cycle.
REQ-028 StallCount SHALL increment on every clock edge where PCWrite=0 and SHALL saturate at 16'hFFFF (no wrap).

Reset
REQ-029 When reset=1 at a rising edge, state SHALL become RUN, cnt SHALL become 0 and StallCount SHALL become 0.
REQ-030 While reset=1, the controller SHALL output idle values regardless of other inputs.
REQ-031 Reset asserted in MULBUSY SHALL abort the multiply hold; the first cycle after reset SHALL be idle.

Verification
REQ-032 Load-use: ID_EX_MemRead=1, ID_EX_Rt=8, IF_ID_Rs=8 for one cycle -> PCWrite=0 and ID_EX_Bubble=1 for 1 cycle; StallCount=1.
REQ-033 No false stall: ID_EX_Rt=0 with IF_ID_Rs=0, or IF_ID_UsesRt=0 with an Rt-only match -> idle outputs.
REQ-034 Multiply with MUL_CYCLES=4: ID_EX_MultStart pulse at cycle t -> hold in t..t+2, idle in t+3, StallCount=3; repeat with MUL_CYCLES=2 -> hold 1 cycle.
REQ-035 Priority: EX_BranchTaken=1 together with load-use and IF_ID_Jump=1 -> IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1.
REQ-036 Reset mid-MULBUSY (cycle t+1 of a MUL_CYCLES=4 multiply) -> idle at t+2, StallCount=0.
REQ-037 Saturation: force 65536+ stall cycles -> StallCount holds at 16'hFFFF.
